sgh_slow_sequencer: RTL and testbench

- Sequences the I2C slowdown/speedup engine for the S-RGH Trinity glitch flow.
- Watches the CPU POST bit and requests slowdown (`i2c_send`=1) at a programmed POST edge count.
- Restores speed (`i2c_send`=0) when the glitch stage reports completion or a window times out.
- Holds each request long enough for the full 256-bit message plus slowdown delay frames to go out. Sits between the POST input pins and the I2C engine, on the 400 kHz clock.

---
 rtl/sgh_pkg.sv | 34 +++
 rtl/sgh_slow_sequencer_if.sv | 29 ++
 rtl/sgh_sync_edge.sv | 42 ++++
 rtl/sgh_slow_sequencer.sv | 173 +++++++++++++++++
 tb/tb_sgh_slow_sequencer.sv | 252 +++++++++++++++++++++++++
 5 files changed

// File: rtl/sgh_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : sgh_pkg
//  Description : Shared state encoding and default timing constants for the
//                S-RGH slowdown/speedup sequencer.
//  Revision    : 1.0 - initial release
// ============================================================================
package sgh_pkg;

    // I2C message geometry: every message bit is followed by a block of
    // slowdown delay frames, so one full message lasts this many clocks.
    localparam int BIT_POS_MAX     = 255;
    localparam int SLOWDOWN_DELAYS = 31;
    localparam int DEF_MSG_HOLD    = (BIT_POS_MAX + 1) * (SLOWDOWN_DELAYS + 1);

    // 100 ms of slow mode at 400 kHz before a forced speedup.
    localparam int DEF_SLOW_WINDOW = 40000;
    localparam int DEF_POST_EDGES  = 4;
    localparam int DEF_MAX_RETRY   = 3;
    localparam int DEF_CNT_W       = 16;

    typedef enum logic [2:0] {
        ST_IDLE      = 3'd0,
        ST_ARM       = 3'd1,
        ST_SLOW_HOLD = 3'd2,
        ST_SLOW_WAIT = 3'd3,
        ST_FAST_HOLD = 3'd4,
        ST_DONE      = 3'd5,
        ST_RETRY     = 3'd6,
        ST_FAIL      = 3'd7
    } sgh_state_e;

endpackage
`default_nettype wire

// File: rtl/sgh_slow_sequencer_if.sv
`default_nettype none
// ============================================================================
//  Module      : sgh_slow_sequencer_if
//  Description : Pin-side bundle of the slow sequencer: POST / CPU-reset /
//                glitch-done inputs and the I2C request plus debug outputs.
//  Revision    : 1.0 - initial release
// ============================================================================
interface sgh_slow_sequencer_if;
    logic       post_bit;
    logic       glitch_done;
    logic       cpu_rst_n;
    logic       i2c_send;
    logic [2:0] seq_state;
    logic [1:0] attempt;
    logic       fail;

    // Environment side: drives the pins, observes the sequencer.
    modport master (
        output post_bit, glitch_done, cpu_rst_n,
        input  i2c_send, seq_state, attempt, fail
    );

    // Sequencer side.
    modport slave (
        input  post_bit, glitch_done, cpu_rst_n,
        output i2c_send, seq_state, attempt, fail
    );
endinterface
`default_nettype wire

// File: rtl/sgh_sync_edge.sv
`default_nettype none
// ============================================================================
//  Module      : sgh_sync_edge
//  Description : Two-flop synchroniser for an asynchronous pin followed by a
//                one-cycle rise / fall / any-edge strobe generator.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgh_sync_edge #(
    parameter logic RESET_VAL = 1'b0
) (
    input  wire logic clk,
    input  wire logic rst,
    input  wire logic i_async,
    output logic      o_level,
    output logic      o_rise,
    output logic      o_fall,
    output logic      o_edge
);
    logic r_meta;
    logic r_sync;
    logic r_prev;

    // Resynchronise the pin and keep one older sample for edge detection;
    // all three flops reset to the same value so reset never fakes an edge.
    always_ff @(posedge clk) begin
        if (rst) begin
            r_meta <= RESET_VAL;
            r_sync <= RESET_VAL;
            r_prev <= RESET_VAL;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_level = r_sync;
    assign o_rise  = r_sync & ~r_prev;
    assign o_fall  = ~r_sync & r_prev;
    assign o_edge  = r_sync ^ r_prev;
endmodule
`default_nettype wire

// File: rtl/sgh_slow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : sgh_slow_sequencer
//  Description : Requests I2C slowdown after a programmed number of POST bit
//                edges, restores speed on glitch completion or window timeout,
//                and holds every request for a full message time.
//                Optional macro SGH_RETRY_EN: re-arm after a timeout up to
//                MAX_RETRY times instead of failing at once.
//  Revision    : 1.0 - initial release
// ============================================================================
module sgh_slow_sequencer
    import sgh_pkg::*;
#(
    parameter int POST_EDGES  = DEF_POST_EDGES,
    parameter int MSG_HOLD    = DEF_MSG_HOLD,
    parameter int SLOW_WINDOW = DEF_SLOW_WINDOW,
    parameter int MAX_RETRY   = DEF_MAX_RETRY,
    parameter int CNT_W       = DEF_CNT_W
) (
    input  wire logic            clk_400k,
    input  wire logic            rst,
    sgh_slow_sequencer_if.slave  bus
);
    localparam int               c_EDGE_W    = $clog2(POST_EDGES + 1);
    localparam logic [c_EDGE_W-1:0] c_EDGE_LAST = c_EDGE_W'(POST_EDGES - 1);
    localparam logic [CNT_W-1:0] c_HOLD_LAST = CNT_W'(MSG_HOLD - 1);
    localparam logic [CNT_W-1:0] c_WIN_LAST  = CNT_W'(SLOW_WINDOW - 1);

    // Counter must be able to reach both terminal values without saturating.
    generate
        if ((64'(SLOW_WINDOW) > (64'd1 << CNT_W)) || (64'(MSG_HOLD) > (64'd1 << CNT_W))
            || (SLOW_WINDOW < 1) || (MSG_HOLD < 1)) begin : g_cfg_cnt_err
            $error("sgh_slow_sequencer: CNT_W too small for MSG_HOLD/SLOW_WINDOW");
        end
        if ((MAX_RETRY < 0) || (MAX_RETRY > 3) || (POST_EDGES < 1)) begin : g_cfg_param_err
            $error("sgh_slow_sequencer: MAX_RETRY must be 0..3 and POST_EDGES >= 1");
        end
    endgenerate

    logic w_post_lvl, w_post_rise, w_post_fall, w_post_edge;
    logic w_cpu_lvl, w_cpu_rise, w_cpu_fall, w_cpu_edge;
    logic w_unused_strobes;

    // The CPU is assumed held in reset until the synchroniser proves otherwise.
    sgh_sync_edge #(.RESET_VAL(1'b0)) u_sync_post (
        .clk(clk_400k), .rst(rst), .i_async(bus.post_bit),
        .o_level(w_post_lvl), .o_rise(w_post_rise), .o_fall(w_post_fall), .o_edge(w_post_edge)
    );

    sgh_sync_edge #(.RESET_VAL(1'b0)) u_sync_cpu (
        .clk(clk_400k), .rst(rst), .i_async(bus.cpu_rst_n),
        .o_level(w_cpu_lvl), .o_rise(w_cpu_rise), .o_fall(w_cpu_fall), .o_edge(w_cpu_edge)
    );

    assign w_unused_strobes = ^{w_post_lvl, w_post_rise, w_post_fall, w_cpu_rise, w_cpu_edge};

    sgh_state_e          r_state;
    logic [CNT_W-1:0]    r_cnt;
    logic [c_EDGE_W-1:0] r_edge_cnt;
    logic                r_i2c_send;
    logic                r_timed_out;
    logic                r_rst_seen;
    logic                r_fail;
    logic [1:0]          r_attempt;
    logic [CNT_W-1:0]    w_cnt_inc;

    // Shared hold/window counter saturates instead of wrapping.
    assign w_cnt_inc = (r_cnt == '1) ? r_cnt : r_cnt + CNT_W'(1);

    // Main sequencer. r_rst_seen remembers a CPU reset that arrived while the
    // speedup message was still being held, so DONE can fall straight to IDLE.
    always_ff @(posedge clk_400k) begin
        if (rst) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_edge_cnt  <= '0;
            r_i2c_send  <= 1'b0;
            r_timed_out <= 1'b0;
            r_rst_seen  <= 1'b0;
            r_fail      <= 1'b0;
            r_attempt   <= 2'd0;
        end else begin
            case (r_state)
                ST_IDLE: begin
                    r_i2c_send <= 1'b0;
                    r_rst_seen <= 1'b0;
                    if (w_cpu_lvl) begin
                        r_state    <= ST_ARM;
                        r_edge_cnt <= '0;
                    end
                end
                ST_ARM: begin
                    if (!w_cpu_lvl) begin
                        r_state <= ST_IDLE;
                    end else if (w_post_edge) begin
                        r_edge_cnt <= r_edge_cnt + c_EDGE_W'(1);
                        if (r_edge_cnt == c_EDGE_LAST) begin
                            r_i2c_send <= 1'b1;
                            r_cnt      <= '0;
                            r_state    <= ST_SLOW_HOLD;
                        end
                    end
                end
                ST_SLOW_HOLD, ST_SLOW_WAIT: begin
                    if (!w_cpu_lvl) begin
                        // CPU went back into reset: never leave it slowed down.
                        r_i2c_send  <= 1'b0;
                        r_cnt       <= '0;
                        r_timed_out <= 1'b0;
                        r_rst_seen  <= 1'b1;
                        r_state     <= ST_FAST_HOLD;
                    end else if (r_state == ST_SLOW_HOLD) begin
                        // glitch_done ignored until the slowdown message is out.
                        r_cnt <= w_cnt_inc;
                        if (r_cnt >= c_HOLD_LAST) begin
                            r_state <= ST_SLOW_WAIT;
                        end
                    end else if (bus.glitch_done || (r_cnt >= c_WIN_LAST)) begin
                        // Completion beats a coincident timeout.
                        r_i2c_send  <= 1'b0;
                        r_cnt       <= '0;
                        r_timed_out <= ~bus.glitch_done;
                        r_state     <= ST_FAST_HOLD;
                    end else begin
                        r_cnt <= w_cnt_inc;
                    end
                end
                ST_FAST_HOLD: begin
                    r_cnt <= w_cnt_inc;
                    if (w_cpu_fall) begin
                        r_rst_seen <= 1'b1;
                    end
                    if (r_cnt >= c_HOLD_LAST) begin
                        r_state <= r_timed_out ? ST_RETRY : ST_DONE;
                    end
                end
                ST_DONE: begin
                    r_i2c_send <= 1'b0;
                    if (w_cpu_fall || r_rst_seen) begin
                        r_state <= ST_IDLE;
                    end
                end
                ST_RETRY: begin
`ifdef SGH_RETRY_EN
                    if (r_attempt < 2'(MAX_RETRY)) begin
                        r_attempt <= r_attempt + 2'd1;
                        r_state   <= ST_IDLE;
                    end else begin
                        r_fail  <= 1'b1;
                        r_state <= ST_FAIL;
                    end
`else
                    r_fail  <= 1'b1;
                    r_state <= ST_FAIL;
`endif
                end
                ST_FAIL: begin
                    r_fail     <= 1'b1;
                    r_i2c_send <= 1'b0;
                end
                default: begin
                    r_state <= ST_IDLE;
                end
            endcase
        end
    end

    assign bus.i2c_send  = r_i2c_send;
    assign bus.seq_state = r_state;
    assign bus.attempt   = r_attempt;
    assign bus.fail      = r_fail;
endmodule
`default_nettype wire

// File: tb/tb_sgh_slow_sequencer.sv
`default_nettype none
// ============================================================================
//  Module      : tb_sgh_slow_sequencer
//  Description : Directed self-checking bench for sgh_slow_sequencer with
//                shortened hold/window times. Handles both SGH_RETRY_EN builds.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_sgh_slow_sequencer;
    localparam int P_EDGES = 4;
    localparam int P_HOLD  = 256;
    localparam int P_WIN   = 600;
    localparam int P_CNTW  = 16;
    localparam int P_RETRY = 3;

    logic clk_400k = 1'b0;
    logic rst;

    always #5 clk_400k = ~clk_400k;

    sgh_slow_sequencer_if bus();

    sgh_slow_sequencer #(
        .POST_EDGES(P_EDGES), .MSG_HOLD(P_HOLD), .SLOW_WINDOW(P_WIN),
        .MAX_RETRY(P_RETRY), .CNT_W(P_CNTW)
    ) u_dut (
        .clk_400k(clk_400k),
        .rst(rst),
        .bus(bus)
    );

    int          n_cmp = 0;
    int          n_bad = 0;
    logic [31:0] exp_q[$];

    task automatic tick();
        @(posedge clk_400k);
        #1;
    endtask

    task automatic sb_push(input logic [31:0] v);
        exp_q.push_back(v);
    endtask

    task automatic sb_check(input string tag, input logic [31:0] obs);
        logic [31:0] exp;
        n_cmp++;
        if (exp_q.size() == 0) begin
            n_bad++;
            $error("FAIL %s: observed %0d, no expected value queued", tag, obs);
        end else begin
            exp = exp_q.pop_front();
            assert (obs === exp) else begin
                n_bad++;
                $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
            end
        end
    endtask

    // Bounded waits: n = cycles taken, or -1 if the budget expired.
    task automatic wait_state(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (bus.seq_state !== s && n < budget) begin tick(); n++; end
        if (bus.seq_state !== s) n = -1;
    endtask

    task automatic wait_leave(input logic [2:0] s, input int budget, output int n);
        n = 0;
        while (bus.seq_state === s && n < budget) begin tick(); n++; end
        if (bus.seq_state === s) n = -1;
    endtask

    task automatic wait_i2c(input logic v, input int budget, output int n);
        n = 0;
        while (bus.i2c_send !== v && n < budget) begin tick(); n++; end
        if (bus.i2c_send !== v) n = -1;
    endtask

    // Number of consecutive samples with i2c_send high, starting now.
    task automatic count_high(input int budget, output int n);
        n = 0;
        while (bus.i2c_send === 1'b1 && n < budget) begin n++; tick(); end
    endtask

    // CPU reset pulse, confirm ARM, then POST_EDGES toggles; returns the
    // cycles from the last toggle until i2c_send is seen high.
    task automatic arm_to_slow(input int gap, output int lat);
        int n;
        bus.cpu_rst_n = 1'b0;
        repeat (4) tick();
        bus.cpu_rst_n = 1'b1;
        sb_push(32'd1);
        wait_state(3'd1, 10, n);
        sb_check("arm_entry", 32'(bus.seq_state));
        for (int i = 0; i < P_EDGES; i++) begin
            bus.post_bit = ~bus.post_bit;
            if (i < P_EDGES - 1) repeat (gap) tick();
        end
        wait_i2c(1'b1, 10, lat);
    endtask

    initial begin
        int n;
        int hi;
        rst             = 1'b1;
        bus.post_bit    = 1'b0;
        bus.glitch_done = 1'b0;
        bus.cpu_rst_n   = 1'b0;
        repeat (2) tick();

        // Reset values
        sb_push(32'd0); sb_check("rst_i2c", 32'(bus.i2c_send));
        sb_push(32'd0); sb_check("rst_state", 32'(bus.seq_state));
        sb_push(32'd0); sb_check("rst_attempt", 32'(bus.attempt));
        sb_push(32'd0); sb_check("rst_fail", 32'(bus.fail));
        rst = 1'b0;

        // Nominal: edges 50 apart, glitch_done at cycle 100 of the slow hold.
        arm_to_slow(50, n);
        sb_push(32'd1); sb_check("nom_lat_le3", 32'(n >= 1 && n <= 3));
        sb_push(32'd2); sb_check("nom_slow_hold", 32'(bus.seq_state));
        repeat (100) tick();
        sb_push(32'd1); sb_check("nom_high_at_100", 32'(bus.i2c_send));
        bus.glitch_done = 1'b1;
        // Slow phase spans P_HOLD hold samples plus the SLOW_WAIT sample that
        // sees glitch_done: P_HOLD+1 high samples, 100 of them already gone.
        sb_push(32'(P_HOLD + 1 - 100));
        count_high(P_WIN + 10, hi);
        sb_check("nom_high_remaining", 32'(hi));
        sb_push(32'd4); sb_check("nom_fast_hold", 32'(bus.seq_state));
        bus.glitch_done = 1'b0;
        sb_push(32'(P_HOLD));
        wait_state(3'd5, P_HOLD + 20, n);
        sb_check("nom_fast_hold_len", 32'(n));
        repeat (20) tick();
        sb_push(32'd5); sb_check("nom_done_sticky", 32'(bus.seq_state));
        sb_push(32'd0); sb_check("nom_done_i2c", 32'(bus.i2c_send));

        // Timeout: glitch_done never asserted.
        arm_to_slow(10, n);
        sb_push(32'd1); sb_check("to_lat_le3", 32'(n >= 1 && n <= 3));
        sb_push(32'(P_WIN));
        count_high(P_WIN + 20, hi);
        sb_check("to_high_len", 32'(hi));
        sb_push(32'd4); sb_check("to_fast_hold", 32'(bus.seq_state));
        sb_push(32'(P_HOLD));
        wait_leave(3'd4, P_HOLD + 20, n);
        sb_check("to_fast_hold_len", 32'(n));
        sb_push(32'd6); sb_check("to_retry", 32'(bus.seq_state));
        tick();
`ifdef SGH_RETRY_EN
        sb_push(32'd0); sb_check("to_retry_idle", 32'(bus.seq_state));
        sb_push(32'd1); sb_check("to_attempt1", 32'(bus.attempt));
        sb_push(32'd0); sb_check("to_fail0", 32'(bus.fail));
        // Three more timeouts exhaust the retries.
        for (int k = 2; k <= 4; k++) begin
            arm_to_slow(10, n);
            sb_push(32'(P_WIN));
            count_high(P_WIN + 20, hi);
            sb_check("ex_high_len", 32'(hi));
            wait_leave(3'd4, P_HOLD + 20, n);
            sb_push(32'd6); sb_check("ex_retry", 32'(bus.seq_state));
            tick();
            if (k < 4) begin
                sb_push(32'd0); sb_check("ex_idle", 32'(bus.seq_state));
                sb_push(32'(k)); sb_check("ex_attempt", 32'(bus.attempt));
            end else begin
                sb_push(32'd7); sb_check("ex_fail_state", 32'(bus.seq_state));
                sb_push(32'd3); sb_check("ex_attempt_sat", 32'(bus.attempt));
                sb_push(32'd1); sb_check("ex_fail", 32'(bus.fail));
            end
        end
        repeat (30) tick();
        sb_push(32'd0); sb_check("ex_i2c_low", 32'(bus.i2c_send));
        sb_push(32'd1); sb_check("ex_fail_sticky", 32'(bus.fail));
`else
        sb_push(32'd7); sb_check("to_fail_state", 32'(bus.seq_state));
        sb_push(32'd1); sb_check("to_fail", 32'(bus.fail));
        sb_push(32'd0); sb_check("to_attempt0", 32'(bus.attempt));
        bus.cpu_rst_n = 1'b0;
        repeat (5) tick();
        bus.cpu_rst_n = 1'b1;
        repeat (5) tick();
        sb_push(32'd7); sb_check("fail_state_sticky", 32'(bus.seq_state));
        sb_push(32'd1); sb_check("fail_sticky", 32'(bus.fail));
        sb_push(32'd0); sb_check("fail_i2c_low", 32'(bus.i2c_send));
`endif
        rst = 1'b1;
        tick();
        sb_push(32'd0); sb_check("rst2_state", 32'(bus.seq_state));
        sb_push(32'd0); sb_check("rst2_fail", 32'(bus.fail));
        sb_push(32'd0); sb_check("rst2_attempt", 32'(bus.attempt));
        rst = 1'b0;

        // CPU reset while in SLOW_WAIT.
        arm_to_slow(10, n);
        sb_push(32'd1); sb_check("ab_lat_le3", 32'(n >= 1 && n <= 3));
        repeat (P_HOLD + 50) tick();
        sb_push(32'd3); sb_check("ab_slow_wait", 32'(bus.seq_state));
        bus.cpu_rst_n = 1'b0;
        sb_push(32'd1);
        wait_i2c(1'b0, 10, n);
        sb_check("ab_i2c_drop_le3", 32'(n >= 1 && n <= 3));
        sb_push(32'd4); sb_check("ab_fast_hold", 32'(bus.seq_state));
        sb_push(32'(P_HOLD));
        wait_leave(3'd4, P_HOLD + 20, n);
        sb_check("ab_fast_hold_len", 32'(n));
        sb_push(32'd5); sb_check("ab_done", 32'(bus.seq_state));
        tick();
        sb_push(32'd0); sb_check("ab_idle", 32'(bus.seq_state));
        sb_push(32'd0); sb_check("ab_attempt", 32'(bus.attempt));
        bus.cpu_rst_n = 1'b1;

        // glitch_done arrives on the very cycle the window expires.
        arm_to_slow(10, n);
        sb_push(32'd1); sb_check("sim_lat_le3", 32'(n >= 1 && n <= 3));
        repeat (P_WIN - 1) tick();
        sb_push(32'd1); sb_check("sim_high_last", 32'(bus.i2c_send));
        sb_push(32'd3); sb_check("sim_slow_wait", 32'(bus.seq_state));
        bus.glitch_done = 1'b1;
        tick();
        bus.glitch_done = 1'b0;
        sb_push(32'd0); sb_check("sim_i2c_fall", 32'(bus.i2c_send));
        sb_push(32'd4); sb_check("sim_fast_hold", 32'(bus.seq_state));
        wait_leave(3'd4, P_HOLD + 20, n);
        sb_push(32'd5); sb_check("sim_done_not_retry", 32'(bus.seq_state));
        sb_push(32'd0); sb_check("sim_attempt", 32'(bus.attempt));

        // Synchronous reset in the middle of SLOW_HOLD.
        arm_to_slow(10, n);
        sb_push(32'd1); sb_check("sr_lat_le3", 32'(n >= 1 && n <= 3));
        repeat (30) tick();
        sb_push(32'd2); sb_check("sr_slow_hold", 32'(bus.seq_state));
        rst = 1'b1;
        tick();
        sb_push(32'd0); sb_check("sr_i2c", 32'(bus.i2c_send));
        sb_push(32'd0); sb_check("sr_state", 32'(bus.seq_state));
        sb_push(32'd0); sb_check("sr_attempt", 32'(bus.attempt));
        sb_push(32'd0); sb_check("sr_fail", 32'(bus.fail));
        rst = 1'b0;
        repeat (5) tick();

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog expired");
    end
endmodule
`default_nettype wire
